alu_result_disp: RTL and testbench

- Downstream stage of the 4-bit subtract/add datapath.
- Captures the 4-bit two's-complement result and its cout/overflow flags on a strobe.
- Derives status flags and converts the result to sign + magnitude.
- Drives two active-low seven-segment digits (sign, magnitude) plus flag LEDs; a latched overflow blinks the display.

---
 rtl/alu_result_disp.sv | 93 +++++++++
 tb/tb_alu_result_disp.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alu_result_disp.sv
// alu_result_disp: captures a 4-bit two's-complement ALU result and shows it as sign + magnitude on seven-segment digits
//   clk, rst        : clock, asynchronous active-high reset
//   res_valid       : one-cycle strobe qualifying res/cout/overflow
//   res, cout,
//   overflow        : result and flags from the subtractor/adder
//   hold            : ignore res_valid and freeze the display (blink timer still runs)
//   clr             : synchronous clear to the blank IDLE display, beats res_valid and hold
//   seg_sign        : sign digit, active-low {dp,g..a}; minus sign when negative
//   seg_mag         : magnitude digit 0..8, active-low, dp off
//   flags           : {ovf, carry, neg, zero} of the captured result
//   busy_ovf        : high while an overflowed result is blinking
module alu_result_disp #(
    parameter logic [23:0] BLINK_DIV = 24'd5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       res_valid,
    input  logic [3:0] res,
    input  logic       cout,
    input  logic       overflow,
    input  logic       hold,
    input  logic       clr,
    output logic [7:0] seg_sign,
    output logic [7:0] seg_mag,
    output logic [3:0] flags,
    output logic       busy_ovf
);
    typedef enum logic [1:0] {IDLE, SHOW, OVF_BLINK} state_t;
    state_t      state_q, state_d;
    logic [3:0]  res_q, res_d, flags_q, flags_d, mag;
    logic [23:0] cnt_q, cnt_d;
    logic        phase_q, phase_d, tc, blank;
    logic [7:0]  mag_seg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end
    assign tc = cnt_q == BLINK_DIV - 24'd1;
    // Counter and phase default to 0, so any capture or exit from OVF_BLINK restarts the blink cleanly.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        flags_d = flags_q;
        cnt_d   = '0;
        phase_d = 1'b0;
        if (clr) begin
            state_d = IDLE;
            res_d   = '0;
            flags_d = '0;
        end else if (res_valid && !hold) begin
            state_d = overflow ? OVF_BLINK : SHOW;
            res_d   = res;
            flags_d = {overflow, cout, res[3], res == 4'd0};
        end else if (state_q == OVF_BLINK) begin
            cnt_d   = tc ? '0 : cnt_q + 24'd1;
            phase_d = phase_q ^ tc;
        end
    end
    // 4-bit negate: 4'b1000 maps to itself, which reads as magnitude 8.
    assign mag = res_q[3] ? ~res_q + 4'd1 : res_q;
    always_comb begin
        mag_seg = 8'hFF;
        case (mag)
            4'd0: mag_seg = 8'hC0;
            4'd1: mag_seg = 8'hF9;
            4'd2: mag_seg = 8'hA4;
            4'd3: mag_seg = 8'hB0;
            4'd4: mag_seg = 8'h99;
            4'd5: mag_seg = 8'h92;
            4'd6: mag_seg = 8'h82;
            4'd7: mag_seg = 8'hF8;
            4'd8: mag_seg = 8'h80;
            default: mag_seg = 8'hFF;
        endcase
    end
    // Outputs decode straight from registers so an async reset blanks them without a clock edge.
    assign blank    = state_q == IDLE || (state_q == OVF_BLINK && phase_q);
    assign seg_sign = (blank || !flags_q[1]) ? 8'hFF : 8'hBF;
    assign seg_mag  = blank ? 8'hFF : mag_seg;
    assign flags    = flags_q;
    assign busy_ovf = state_q == OVF_BLINK;
endmodule

// File: tb/tb_alu_result_disp.sv
// tb_alu_result_disp: scoreboard bench for alu_result_disp with BLINK_DIV=4
module tb_alu_result_disp;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       res_valid = 1'b0;
    logic [3:0] res = '0;
    logic       cout = 1'b0;
    logic       overflow = 1'b0;
    logic       hold = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] seg_sign, seg_mag;
    logic [3:0] flags;
    logic       busy_ovf;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        string      name;
        logic [7:0] s;
        logic [7:0] m;
        logic [3:0] f;
        logic       b;
    } exp_t;
    exp_t q[$];

    alu_result_disp #(.BLINK_DIV(24'd4)) dut (
        .clk(clk), .rst(rst), .res_valid(res_valid), .res(res), .cout(cout),
        .overflow(overflow), .hold(hold), .clr(clr), .seg_sign(seg_sign),
        .seg_mag(seg_mag), .flags(flags), .busy_ovf(busy_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string name, input logic [7:0] s, input logic [7:0] m,
                            input logic [3:0] f, input logic b);
        exp_t e;
        e.name = name; e.s = s; e.m = m; e.f = f; e.b = b;
        q.push_back(e);
    endtask

    task automatic strobe(input logic [3:0] r, input logic c, input logic o);
        res = r; cout = c; overflow = o; res_valid = 1'b1;
        step();
        res_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (seg_sign !== e.s || seg_mag !== e.m || flags !== e.f || busy_ovf !== e.b) begin
                errors++;
                $display("FAIL %s: got sign=%h mag=%h flags=%b busy=%b, want sign=%h mag=%h flags=%b busy=%b",
                         e.name, seg_sign, seg_mag, flags, busy_ovf, e.s, e.m, e.f, e.b);
            end
        end
    end

    initial begin
        repeat (3) step();
        rst = 1'b0;
        push_exp("reset", 8'hFF, 8'hFF, 4'b0000, 1'b0);
        step();
        strobe(4'b1101, 1'b1, 1'b0);
        push_exp("neg3", 8'hBF, 8'hB0, 4'b0110, 1'b0);
        step();
        strobe(4'b1000, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            if ((k / 4) % 2 == 1) push_exp("blink_off", 8'hFF, 8'hFF, 4'b1010, 1'b1);
            else push_exp("blink_on", 8'hBF, 8'h80, 4'b1010, 1'b1);
            step();
        end
        strobe(4'b0101, 1'b0, 1'b0);
        push_exp("pos5", 8'hFF, 8'h92, 4'b0000, 1'b0);
        step();
        strobe(4'b0111, 1'b0, 1'b1);
        push_exp("hold_blink_on", 8'hFF, 8'hF8, 4'b1000, 1'b1);
        hold = 1'b1; res = 4'b0001; overflow = 1'b0; res_valid = 1'b1;
        for (int k = 1; k < 6; k++) begin
            step();
            if (k >= 4) push_exp("hold_blink_off", 8'hFF, 8'hFF, 4'b1000, 1'b1);
            else push_exp("hold_blink_on", 8'hFF, 8'hF8, 4'b1000, 1'b1);
        end
        hold = 1'b0; res_valid = 1'b0;
        step();
        strobe(4'b0000, 1'b0, 1'b0);
        push_exp("zero", 8'hFF, 8'hC0, 4'b0001, 1'b0);
        hold = 1'b1; res = 4'b0111; res_valid = 1'b1;
        step();
        push_exp("hold1", 8'hFF, 8'hC0, 4'b0001, 1'b0);
        step();
        push_exp("hold2", 8'hFF, 8'hC0, 4'b0001, 1'b0);
        hold = 1'b0;
        step();
        res_valid = 1'b0;
        push_exp("unhold7", 8'hFF, 8'hF8, 4'b0000, 1'b0);
        res = 4'b0011; res_valid = 1'b1;
        step();
        push_exp("burst1", 8'hFF, 8'hB0, 4'b0000, 1'b0);
        res = 4'b0110;
        step();
        res_valid = 1'b0;
        push_exp("last_wins", 8'hFF, 8'h82, 4'b0000, 1'b0);
        step();
        strobe(4'b1000, 1'b0, 1'b1);
        push_exp("pre_clr", 8'hBF, 8'h80, 4'b1010, 1'b1);
        clr = 1'b1; res = 4'b0001; res_valid = 1'b1;
        step();
        clr = 1'b0; res_valid = 1'b0;
        push_exp("clr", 8'hFF, 8'hFF, 4'b0000, 1'b0);
        step();
        push_exp("clr_idle", 8'hFF, 8'hFF, 4'b0000, 1'b0);
        step();
        strobe(4'b1001, 1'b1, 1'b1);
        push_exp("pre_rst", 8'hBF, 8'hF8, 4'b1110, 1'b1);
        step();
        #1 rst = 1'b1;
        push_exp("async_rst", 8'hFF, 8'hFF, 4'b0000, 1'b0);
        step();
        rst = 1'b0;
        step();
        strobe(4'b0010, 1'b0, 1'b0);
        push_exp("after_rst", 8'hFF, 8'hA4, 4'b0000, 1'b0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
